// File: rtl/mcu_ahb_pkg.sv
// Shared AHB-Lite encodings plus the command alignment rule used by initiators.
package mcu_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Natural alignment for byte/half/word; anything wider than a word is illegal.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    logic bad;
    bad = 1'b0;
    if (size == HSIZE_HALF)      bad = addr_lo[0];
    else if (size == HSIZE_WORD) bad = (addr_lo != 2'b00);
    else if (size > HSIZE_WORD)  bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mcu_ahb_master_if.sv
// Command/response stream and AHB-Lite bus signals of the initiator.
interface mcu_ahb_master_if #(parameter int ADDR_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HRESP;
  logic [31:0]       HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HREADY, HRESP, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HREADY, HRESP, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/mcu_ahb_master.sv
// AHB-Lite single-transfer initiator: valid/ready commands in, one in-order
// response out per command. Two-slot pipeline (address slot, data slot).
module mcu_ahb_master
  import mcu_ahb_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter logic [3:0] HPROT_VAL = HPROT_DEFAULT
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  mcu_ahb_master_if.master bus
);

  logic              a_valid, a_write, a_supp;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_size;
  logic [31:0]       a_wdata;
  logic              d_valid, d_write;
  logic [31:0]       d_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;

  logic cmd_mis, err1, adv, d_done, cmd_ready, take_aligned, take_mis;

  // Handshake and pipeline-advance decode.
  always_comb begin
    cmd_mis   = misaligned(bus.cmd_addr[1:0], bus.cmd_size);
    // First cycle of a two-cycle ERROR: the pipelined address must be pulled back.
    err1      = d_valid & bus.HRESP & ~bus.HREADY;
    adv       = a_valid & ~a_supp & bus.HREADY;
    d_done    = d_valid & bus.HREADY;
    // Misaligned commands wait for an empty pipe so their error response stays in order.
    cmd_ready = cmd_mis ? (~a_valid & ~d_valid)
                        : (~a_valid | (bus.HREADY & ~a_supp & ~err1));
    take_aligned = bus.cmd_valid & cmd_ready & ~cmd_mis;
    take_mis     = bus.cmd_valid & cmd_ready &  cmd_mis;
  end

  // Address slot: load on accept, drain on advance, hold through wait/error.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
      a_size  <= '0;
      a_wdata <= '0;
      a_supp  <= 1'b0;
    end else begin
      if (take_aligned) begin
        a_valid <= 1'b1;
        a_write <= bus.cmd_write;
        a_addr  <= bus.cmd_addr;
        a_size  <= bus.cmd_size;
        a_wdata <= bus.cmd_wdata;
      end else if (adv) begin
        a_valid <= 1'b0;
      end
      // Suppress the address phase for the second ERROR cycle, then reissue.
      if (err1)        a_supp <= 1'b1;
      else if (d_done) a_supp <= 1'b0;
    end
  end

  // Data slot: filled by address advance, retired when HREADY completes it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_wdata <= '0;
    end else if (adv) begin
      d_valid <= 1'b1;
      d_write <= a_write;
      d_wdata <= a_wdata;
    end else if (d_done) begin
      d_valid <= 1'b0;
    end
  end

  // Response register: one pulse per completed transfer or rejected command.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= d_done | take_mis;
      rsp_err   <= take_mis | (d_done & bus.HRESP);
      rsp_rdata <= (d_done & ~d_write & ~bus.HRESP) ? bus.HRDATA : 32'h0;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.busy      = a_valid | d_valid;
  assign bus.HTRANS    = (a_valid & ~a_supp) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_addr;
  assign bus.HSIZE     = a_size;
  assign bus.HWRITE    = a_write;
  assign bus.HWDATA    = d_wdata;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_mcu_ahb_master.sv
// Directed bench for mcu_ahb_master: stimulus pushes expected responses into
// a queue, a negedge monitor pops and compares every rsp_valid pulse.
module tb_mcu_ahb_master;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  mcu_ahb_master_if #(.ADDR_W(32)) bus();

  mcu_ahb_master #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h at %0t", n, act, req, $time);
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge HCLK) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_err", bus.rsp_err, e[32]);
        chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt(); @(posedge HCLK); #1; endtask
  task automatic settle(); #3; endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_size = s; bus.cmd_wdata = d;
  endtask

  task automatic idle_cmd();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_size = 3'd2; bus.cmd_wdata = '0;
  endtask

  task automatic ck_bus(input string n, input logic [1:0] tr, input logic [31:0] a);
    chk({n, "_htrans"}, bus.HTRANS, tr);
    chk({n, "_haddr"}, bus.HADDR, a);
  endtask

  initial begin
    HRESETn = 1'b0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'hFFFF_FFFF;
    idle_cmd();
    #3;
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_hsize", bus.HSIZE, 0);
    chk("rst_hwrite", bus.HWRITE, 0);
    chk("rst_hwdata", bus.HWDATA, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("hburst", bus.HBURST, 0);
    chk("hprot", bus.HPROT, 4'b0011);
    nxt(); nxt();
    HRESETn = 1'b1;
    nxt();

    // 1: single word write, zero wait states
    drive(1'b1, 32'h4000_0010, 3'd2, 32'hDEAD_BEEF); exp_q.push_back({1'b0, 32'h0});
    settle(); chk("t1_ready", bus.cmd_ready, 1);
    nxt(); idle_cmd(); settle();
    ck_bus("t1_a", 2'b10, 32'h4000_0010);
    chk("t1_hwrite", bus.HWRITE, 1); chk("t1_hsize", bus.HSIZE, 2);
    nxt(); settle();
    chk("t1_d_htrans", bus.HTRANS, 0); chk("t1_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
    chk("t1_d_busy", bus.busy, 1);
    nxt(); settle(); chk("t1_rsp_busy", bus.busy, 0);
    nxt();

    // 2: three back-to-back reads
    drive(1'b0, 32'h0, 3'd2, 0); exp_q.push_back({1'b0, 32'h11});
    nxt(); drive(1'b0, 32'h4, 3'd2, 0); exp_q.push_back({1'b0, 32'h22});
    settle(); ck_bus("t2_a0", 2'b10, 32'h0); chk("t2_rdy1", bus.cmd_ready, 1);
    nxt(); drive(1'b0, 32'h8, 3'd2, 0); exp_q.push_back({1'b0, 32'h33}); bus.HRDATA = 32'h11;
    settle(); ck_bus("t2_a1", 2'b10, 32'h4); chk("t2_rdy2", bus.cmd_ready, 1);
    nxt(); idle_cmd(); bus.HRDATA = 32'h22;
    settle(); ck_bus("t2_a2", 2'b10, 32'h8);
    nxt(); bus.HRDATA = 32'h33; settle(); chk("t2_idle", bus.HTRANS, 0);
    nxt(); bus.HRDATA = 32'hFFFF_FFFF; nxt(); nxt();

    // 3: read with three wait states, next read queued behind it
    drive(1'b0, 32'h4000_0020, 3'd2, 0); exp_q.push_back({1'b0, 32'hCAFE_0020});
    nxt(); drive(1'b0, 32'h4000_0024, 3'd2, 0); exp_q.push_back({1'b0, 32'hCAFE_0024});
    settle(); ck_bus("t3_a0", 2'b10, 32'h4000_0020);
    nxt(); idle_cmd(); bus.HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle(); ck_bus("t3_wait", 2'b10, 32'h4000_0024);
      if (i == 0) chk("t3_wait_ready", bus.cmd_ready, 0);
      nxt();
    end
    bus.HREADY = 1'b1; bus.HRDATA = 32'hCAFE_0020;
    settle(); ck_bus("t3_rel", 2'b10, 32'h4000_0024);
    nxt(); bus.HRDATA = 32'hCAFE_0024; settle(); chk("t3_idle", bus.HTRANS, 0);
    nxt(); bus.HRDATA = 32'hFFFF_FFFF; nxt(); nxt();

    // 4: ERROR on write 0x100 with read 0x104 pipelined
    drive(1'b1, 32'h100, 3'd2, 32'h5555_AAAA); exp_q.push_back({1'b1, 32'h0});
    nxt(); drive(1'b0, 32'h104, 3'd2, 0); exp_q.push_back({1'b0, 32'h1040});
    settle(); ck_bus("t4_a0", 2'b10, 32'h100);
    nxt(); idle_cmd(); bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    settle(); ck_bus("t4_err1", 2'b10, 32'h104);
    nxt(); bus.HREADY = 1'b1;
    settle(); chk("t4_err2_htrans", bus.HTRANS, 0); chk("t4_err2_busy", bus.busy, 1);
    nxt(); bus.HRESP = 1'b0;
    settle(); ck_bus("t4_reissue", 2'b10, 32'h104);
    nxt(); bus.HRDATA = 32'h1040; settle(); chk("t4_idle", bus.HTRANS, 0);
    nxt(); bus.HRDATA = 32'hFFFF_FFFF; nxt(); nxt();

    // 5: misaligned commands rejected locally, no bus transfer
    drive(1'b0, 32'h4000_0001, 3'd1, 0); exp_q.push_back({1'b1, 32'h0});
    settle(); chk("t5_h_ready", bus.cmd_ready, 1); chk("t5_h_htrans", bus.HTRANS, 0);
    nxt(); drive(1'b0, 32'h4000_0002, 3'd2, 0); exp_q.push_back({1'b1, 32'h0});
    settle(); chk("t5_w_ready", bus.cmd_ready, 1); chk("t5_h_after", bus.HTRANS, 0);
    nxt(); drive(1'b0, 32'h4000_0000, 3'd3, 0); exp_q.push_back({1'b1, 32'h0});
    settle(); chk("t5_s3_ready", bus.cmd_ready, 1); chk("t5_w_after", bus.HTRANS, 0);
    nxt(); idle_cmd(); settle(); chk("t5_s3_after", bus.HTRANS, 0); chk("t5_busy", bus.busy, 0);
    nxt();
    // misaligned command must wait behind an in-flight transfer
    drive(1'b0, 32'h200, 3'd2, 0); exp_q.push_back({1'b0, 32'h2000});
    nxt(); drive(1'b0, 32'h201, 3'd1, 0); exp_q.push_back({1'b1, 32'h0});
    settle(); chk("t5_blk_a", bus.cmd_ready, 0);
    nxt(); bus.HRDATA = 32'h2000; settle(); chk("t5_blk_d", bus.cmd_ready, 0);
    nxt(); bus.HRDATA = 32'hFFFF_FFFF; settle(); chk("t5_rdy", bus.cmd_ready, 1);
    nxt(); idle_cmd(); settle(); chk("t5_no_xfer", bus.HTRANS, 0);
    nxt(); nxt();

    // 6: reset during a wait-stated data phase
    drive(1'b0, 32'h300, 3'd2, 0);
    nxt(); idle_cmd();
    nxt(); bus.HREADY = 1'b0; settle(); chk("t6_busy_pre", bus.busy, 1);
    HRESETn = 1'b0; #1;
    chk("t6_htrans", bus.HTRANS, 0); chk("t6_busy", bus.busy, 0); chk("t6_rsp", bus.rsp_valid, 0);
    nxt(); bus.HREADY = 1'b1; nxt();
    HRESETn = 1'b1;
    nxt();
    drive(1'b1, 32'h400, 3'd2, 32'h1234_5678); exp_q.push_back({1'b0, 32'h0});
    nxt(); idle_cmd(); settle(); ck_bus("t6_a", 2'b10, 32'h400);
    nxt(); settle(); chk("t6_hwdata", bus.HWDATA, 32'h1234_5678);
    nxt(); nxt(); nxt(); nxt();

    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
